// File: rtl/jtframe_credits_pkg.sv
// Shared definitions for the credits text writer: command codes, page geometry,
// default character codes and the digit-to-character helpers.
package jtframe_credits_pkg;

  localparam int COLS = 32;
  localparam int ROWS = 32;

  localparam logic [6:0] DEF_BLANK = 7'h20;
  localparam logic [6:0] DEF_ZERO  = 7'h30;
  localparam logic [6:0] DEF_ALPHA = 7'h41;

  typedef enum logic [1:0] {
    CMD_HEX = 2'd0,
    CMD_DEC = 2'd1,
    CMD_CLR = 2'd2,
    CMD_CHR = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CONV,
    ST_WRITE,
    ST_CLEAR,
    ST_FIN
  } state_e;

  function automatic logic [6:0] digit_char(input logic [3:0] nib,
                                            input logic [6:0] zero,
                                            input logic [6:0] alpha);
    if (nib < 4'd10) return zero + {3'b000, nib};
    else             return alpha + {3'b000, nib} - 7'd10;
  endfunction

  // Picks digit idx (0 = least significant) out of a packed 5-digit word.
  function automatic logic [3:0] nibble(input logic [19:0] word, input logic [2:0] idx);
    return word[4*idx +: 4];
  endfunction

endpackage

// File: rtl/jtframe_bin2bcd.sv
// Sequential 16-bit binary to 5-digit BCD converter (double dabble).
// The first shift happens on the start edge, so done rises 16 cycles after start.
module jtframe_bin2bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic [19:0] bcd,
  output logic        done
);

  logic [15:0] sr_q, sr_d;
  logic [19:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic [19:0] adj;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    sr_d  = sr_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      // With an all-zero BCD word the first iteration needs no adjust step.
      sr_d  = {bin[14:0], 1'b0};
      bcd_d = {19'd0, bin[15]};
      cnt_d = 4'd15;
      run_d = 1'b1;
    end else if (run_q && cnt_q != 4'd0) begin
      {bcd_d, sr_d} = {adj[18:0], sr_q, 1'b0};
      cnt_d         = cnt_q - 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign bcd  = bcd_q;
  assign done = run_q && (cnt_q == 4'd0);

endmodule

// File: rtl/jtframe_credits_print.sv
// Command-driven text writer feeding the credits overlay VRAM port.
// Define JTFRAME_CREDITS_DEC_EN to build the decimal print path (cmd 1).
module jtframe_credits_print
  import jtframe_credits_pkg::*;
#(
  parameter logic [6:0] BLANK = DEF_BLANK,
  parameter logic [6:0] ZERO  = DEF_ZERO,
  parameter logic [6:0] ALPHA = DEF_ALPHA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [1:0]  cmd,
  input  logic [15:0] value,
  input  logic [4:0]  row,
  input  logic [4:0]  col,
  input  logic [1:0]  ndig,
  input  logic        hl,
  output logic        busy,
  output logic        done,
  output logic [7:0]  vram_din,
  output logic [9:0]  vram_addr,
  output logic        vram_we
);

  localparam logic [9:0] LAST_ADDR = 10'(COLS * ROWS - 1);

  state_e      state_q, state_d;
  cmd_e        cmd_q, cmd_d;
  logic [15:0] val_q, val_d;
  logic [4:0]  row_q, row_d, col_q, col_d;
  logic [1:0]  ndig_q, ndig_d;
  logic        hl_q, hl_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d, done_q, done_d, we_q, we_d;
  logic [7:0]  din_q, din_d;
  logic [9:0]  addr_q, addr_d;
  logic [2:0]  idx;
  logic [6:0]  next_char;

`ifdef JTFRAME_CREDITS_DEC_EN
  logic        conv_start, conv_done;
  logic [19:0] bcd;

  jtframe_bin2bcd u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (val_q),
    .bcd   (bcd),
    .done  (conv_done)
  );
`endif

  // cnt_q holds the index of the digit currently on the bus; idx is the next one.
  assign idx = cnt_q - 3'd1;

  always_comb begin
    next_char = val_q[6:0];
    case (cmd_q)
      CMD_HEX: next_char = digit_char(nibble({4'd0, val_q}, idx), ZERO, ALPHA);
`ifdef JTFRAME_CREDITS_DEC_EN
      CMD_DEC: next_char = digit_char(nibble(bcd, idx), ZERO, ALPHA);
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    val_d   = val_q;
    row_d   = row_q;
    col_d   = col_q;
    ndig_d  = ndig_q;
    hl_d    = hl_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    we_d    = 1'b0;
    din_d   = din_q;
    addr_d  = addr_q;
`ifdef JTFRAME_CREDITS_DEC_EN
    conv_start = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cmd_d   = cmd_e'(cmd);
          val_d   = value;
          row_d   = row;
          col_d   = col;
          ndig_d  = ndig;
          hl_d    = hl;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        addr_d = {row_q, col_q};
        case (cmd_q)
          CMD_HEX: begin
            cnt_d   = {1'b0, ndig_q};
            we_d    = 1'b1;
            din_d   = {hl_q, digit_char(nibble({4'd0, val_q}, {1'b0, ndig_q}), ZERO, ALPHA)};
            state_d = ST_WRITE;
          end
          CMD_CHR: begin
            cnt_d   = 3'd0;
            we_d    = 1'b1;
            din_d   = {hl_q, val_q[6:0]};
            state_d = ST_WRITE;
          end
          CMD_CLR: begin
            addr_d  = '0;
            we_d    = 1'b1;
            din_d   = {1'b0, BLANK};
            state_d = ST_CLEAR;
          end
          default: begin
`ifdef JTFRAME_CREDITS_DEC_EN
            conv_start = 1'b1;
            state_d    = ST_CONV;
`else
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_FIN;
`endif
          end
        endcase
      end
      ST_CONV: begin
`ifdef JTFRAME_CREDITS_DEC_EN
        if (conv_done) begin
          cnt_d   = 3'd4;
          we_d    = 1'b1;
          din_d   = {hl_q, digit_char(bcd[19:16], ZERO, ALPHA)};
          state_d = ST_WRITE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_WRITE: begin
        if (cnt_q == 3'd0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          // Column wraps inside the row; the row bits never see a carry.
          cnt_d  = idx;
          we_d   = 1'b1;
          addr_d = {addr_q[9:5], addr_q[4:0] + 5'd1};
          din_d  = {hl_q, next_char};
        end
      end
      ST_CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          we_d   = 1'b1;
          addr_d = addr_q + 10'd1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_HEX;
      val_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      ndig_q  <= '0;
      hl_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      din_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      val_q   <= val_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ndig_q  <= ndig_d;
      hl_q    <= hl_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign vram_we   = we_q;
  assign vram_din  = din_q;
  assign vram_addr = addr_q;

endmodule
